// File: rtl/via_serial_link.sv
// Bit-serial engine between the VIA shift register (CB1/CB2) and the keyboard/ADB byte side.
// Mode 0 runs the Mac Plus keyboard handshake, mode 1 the Mac SE ADB transceiver.
//
// state   | meaning
// IDLE    | clock parked high, waiting for a Mac start (mode 0) or listen edge / queued byte (mode 1)
// TX      | clocking a frame in from the Mac on CB2
// WAIT_RX | mode 0: frame received, waiting for the Mac to release CB2 and a reply byte
// RX      | clocking the FIFO head out to the Mac MSB first
module via_serial_link #(
    parameter int DATA_W   = 8,
    parameter int DIV_PLUS = 1300,
    parameter int DIV_ADB  = 127,
    parameter int FIFO_AW  = 2,
    parameter int WAIT_TO  = 0
) (
    input  logic              clk32,
    input  logic              _systemReset,
    input  logic              clk8_en_p,
    input  logic              cpu_reset,
    input  logic              mode,
    input  logic              via_cb2_o,
    input  logic              via_cb2_t,
    input  logic              adb_listen,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_strobe,
    output logic              shift_clk,
    output logic              shift_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_strobe,
    output logic              busy,
    output logic              rx_full,
    output logic              overflow,
    output logic              timeout
);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int DIV_MAX = (DIV_PLUS > DIV_ADB) ? DIV_PLUS : DIV_ADB;
    localparam int CW      = $clog2(DIV_MAX + 2);
    localparam int BW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WW      = $clog2(WAIT_TO + 2);

    localparam logic [CW-1:0]      DIV_P_C   = CW'(DIV_PLUS);
    localparam logic [CW-1:0]      DIV_A_C   = CW'(DIV_ADB);
    localparam logic [BW-1:0]      LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [WW-1:0]      WAIT_LOAD = WW'((WAIT_TO > 0) ? WAIT_TO - 1 : 0);
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, TX, WAIT_RX, RX} state_t;

    state_t              state;
    logic                mode_r;
    logic                listen_q;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bitcnt;
    logic [DATA_W-1:0]   sreg;
    logic [WW-1:0]       wcnt;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW:0]    count;

    logic                din;
    logic                listen_edge;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                fifo_push;
    logic [CW-1:0]       div_load;
    logic [BW-1:0]       rx_idx;
    logic [DATA_W-1:0]   head;

    assign din         = ~via_cb2_t | via_cb2_o;
    assign listen_edge = adb_listen & ~listen_q;
    assign fifo_empty  = (count == '0);
    assign rx_full     = (count == FULL_CNT);
    assign busy        = (state != IDLE);
    assign div_load    = mode_r ? DIV_A_C : DIV_P_C;
    assign rx_idx      = LAST_BIT - bitcnt;
    assign head        = mem[rd_ptr];
    // Pop lands on the final rising toggle of an RX frame.
    assign fifo_pop    = (state == RX) && (cnt == '0) && !shift_clk && (bitcnt == LAST_BIT);
    assign fifo_push   = rx_strobe && (!rx_full || fifo_pop);

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            listen_q   <= 1'b0;
            cnt        <= '0;
            bitcnt     <= '0;
            sreg       <= '0;
            wcnt       <= '0;
            shift_clk  <= 1'b1;
            shift_data <= 1'b1;
            tx_data    <= '0;
            tx_strobe  <= 1'b0;
            timeout    <= 1'b0;
        end else if (cpu_reset) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            listen_q   <= 1'b0;
            cnt        <= '0;
            bitcnt     <= '0;
            sreg       <= '0;
            wcnt       <= '0;
            shift_clk  <= 1'b1;
            shift_data <= 1'b1;
            tx_data    <= '0;
            tx_strobe  <= 1'b0;
            timeout    <= 1'b0;
        end else if (clk8_en_p) begin
            tx_strobe <= 1'b0;
            timeout   <= 1'b0;
            listen_q  <= adb_listen;
            case (state)
                IDLE: begin
                    mode_r    <= mode;
                    cnt       <= '0;
                    bitcnt    <= '0;
                    shift_clk <= 1'b1;
                    if (mode ? listen_edge : !din)
                        state <= TX;
                    else if (mode && !fifo_empty)
                        state <= RX;
                end
                TX, RX: begin
                    // cnt idles at 0, so the first toggle comes on the first tick of the frame
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt       <= div_load;
                        shift_clk <= ~shift_clk;
                        if (shift_clk) begin
                            if (state == TX)
                                sreg <= {sreg[DATA_W-2:0], din};
                            else
                                shift_data <= head[rx_idx];
                        end else if (bitcnt == LAST_BIT) begin
                            cnt    <= '0;
                            bitcnt <= '0;
                            if (state == TX) begin
                                tx_data   <= sreg;
                                tx_strobe <= 1'b1;
                                wcnt      <= WAIT_LOAD;
                                state     <= mode_r ? IDLE : WAIT_RX;
                            end else begin
                                shift_data <= 1'b1;
                                state      <= IDLE;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                WAIT_RX: begin
                    if (din && !fifo_empty) begin
                        state  <= RX;
                        bitcnt <= '0;
                    end else if (WAIT_TO > 0) begin
                        if (wcnt == '0) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (cpu_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clk8_en_p) begin
            if (fifo_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (fifo_push && !fifo_pop)
                count <= count + 1'b1;
            else if (fifo_pop && !fifo_push)
                count <= count - 1'b1;
            if (rx_strobe && !fifo_push)
                overflow <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk32) begin
        if (clk8_en_p && !cpu_reset && fifo_push)
            mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_via_serial_link.sv
// Scoreboard bench for via_serial_link: Plus handshake, ADB frames, FIFO limits, timeout, soft reset.
module tb_via_serial_link;
    logic       clk32 = 1'b0;
    logic       _systemReset;
    logic       clk8_en_p;
    logic       cpu_reset;
    logic       mode;
    logic       via_cb2_o;
    logic       via_cb2_t;
    logic       adb_listen;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       shift_clk;
    logic       shift_data;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       busy;
    logic       rx_full;
    logic       overflow;
    logic       timeout;

    int nchk = 0;
    int nerr = 0;
    int tick_no = 0;
    int strobe_cnt = 0;
    int strobe_tick = 0;
    int to_cnt = 0;
    int nbits = 0;
    logic [7:0] shreg = '0;
    logic prev_sclk = 1'b1;
    logic tx_active = 1'b0;
    logic en_last = 1'b0;
    int rx_q[$];
    int tx_q[$];

    via_serial_link #(
        .DATA_W(8), .DIV_PLUS(3), .DIV_ADB(1), .FIFO_AW(2), .WAIT_TO(50)
    ) dut (
        .clk32(clk32), ._systemReset(_systemReset), .clk8_en_p(clk8_en_p), .cpu_reset(cpu_reset),
        .mode(mode), .via_cb2_o(via_cb2_o), .via_cb2_t(via_cb2_t), .adb_listen(adb_listen),
        .rx_data(rx_data), .rx_strobe(rx_strobe), .shift_clk(shift_clk), .shift_data(shift_data),
        .tx_data(tx_data), .tx_strobe(tx_strobe), .busy(busy), .rx_full(rx_full),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk32 = ~clk32;
    always @(posedge clk32) en_last <= clk8_en_p;

    initial begin
        clk8_en_p = 1'b0;
        forever begin
            repeat (3) @(negedge clk32);
            clk8_en_p = 1'b1;
            @(negedge clk32);
            clk8_en_p = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got %0d ticks want completion", tick_no);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one enable tick and observe the outputs that tick produced.
    task automatic step();
        int exp;
        do @(negedge clk32); while (!en_last);
        tick_no++;
        if (cpu_reset) begin
            nbits = 0;
            rx_q.delete();
        end else begin
            if (prev_sclk && !shift_clk && !tx_active) begin
                shreg = {shreg[6:0], shift_data};
                nbits++;
                if (nbits == 8) begin
                    exp = 'h1FF;
                    if (rx_q.size() > 0) exp = rx_q.pop_front();
                    chk("rx_byte", shreg, exp);
                    nbits = 0;
                end
            end
            if (tx_strobe) begin
                strobe_cnt++;
                strobe_tick = tick_no;
                exp = 'h1FF;
                if (tx_q.size() > 0) exp = tx_q.pop_front();
                chk("tx_data", tx_data, exp);
            end
            if (timeout) begin
                to_cnt++;
                chk("timeout_lat", tick_no - strobe_tick, 50);
            end
        end
        prev_sclk = shift_clk;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_out);
        rx_data   = b;
        rx_strobe = 1'b1;
        if (expect_out) rx_q.push_back(b);
        step();
        rx_strobe = 1'b0;
    endtask

    // Mac drives a frame on CB2: MSB presented first, next bit set after each rising toggle.
    task automatic send_frame(input logic [7:0] b, input bit listen, input int div);
        int start, s0, n;
        logic p;
        logic [7:0] bb;
        bb = b;
        tx_active = 1'b1;
        tx_q.push_back(b);
        via_cb2_o  = bb[7];
        via_cb2_t  = 1'b1;
        adb_listen = listen;
        start = tick_no;
        s0 = strobe_cnt;
        for (int i = 0; i < 7; i++) begin
            n = 0;
            do begin
                p = shift_clk;
                step();
                n++;
            end while (!(!p && shift_clk) && n < 200);
            adb_listen = 1'b0;
            bb = {bb[6:0], 1'b0};
            via_cb2_o = bb[7];
        end
        n = 0;
        while (strobe_cnt == s0 && n < 200) begin
            step();
            n++;
        end
        chk("tx_strobe_cnt", strobe_cnt, s0 + 1);
        chk("tx_latency", strobe_tick - start, 1 + 16 * (div + 1) - div);
        tx_active = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 3000 && (rx_q.size() != 0 || busy); n++) step();
        chk({tag, "_queue"}, rx_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t0, s0;
        _systemReset = 1'b0;
        cpu_reset = 1'b0;
        mode = 1'b0;
        via_cb2_o = 1'b1;
        via_cb2_t = 1'b0;
        adb_listen = 1'b0;
        rx_data = '0;
        rx_strobe = 1'b0;
        repeat (4) @(negedge clk32);
        chk("rst_sclk", shift_clk, 1);
        chk("rst_sdata", shift_data, 1);
        chk("rst_txdata", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {tx_strobe, rx_full, overflow, timeout}, 0);
        _systemReset = 1'b1;
        repeat (3) step();

        // Plus keyboard: Mac sends 0x16, engine waits for a reply
        send_frame(8'h16, 1'b0, 3);
        chk("t1_busy", busy, 1);
        chk("t1_sclk", shift_clk, 1);

        // reply 0x7B once CB2 is released
        push(8'h7B, 1'b1);
        via_cb2_t = 1'b0;
        wait_drain("t2");
        chk("t2_sdata_idle", shift_data, 1);

        // no reply queued: timeout 50 ticks after the frame
        send_frame(8'h2A, 1'b0, 3);
        via_cb2_t = 1'b0;
        t0 = to_cnt;
        for (int n = 0; n < 200 && to_cnt == t0; n++) step();
        chk("t5_timeout", to_cnt, t0 + 1);
        step();
        chk("t5_idle", busy, 0);
        chk("t5_pulse", timeout, 0);

        // ADB: two queued bytes go out back to back
        mode = 1'b1;
        step();
        push(8'hA5, 1'b1);
        push(8'h3C, 1'b1);
        wait_drain("t3");

        // ADB listen frame from the Mac
        send_frame(8'hC3, 1'b1, 1);
        via_cb2_t = 1'b0;
        step();
        chk("adb_idle", busy, 0);

        // FIFO limits
        mode = 1'b0;
        step();
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        chk("t4_not_full", rx_full, 0);
        push(8'h44, 1'b1);
        chk("t4_full", rx_full, 1);
        chk("t4_no_ovf", overflow, 0);
        mode = 1'b1;
        step();
        chk("t4_rx_start", busy, 1);
        repeat (30) step();
        push(8'h55, 1'b1);
        chk("t4_popush_ovf", overflow, 0);
        chk("t4_popush_full", rx_full, 1);
        push(8'h66, 1'b0);
        chk("t4_ovf", overflow, 1);
        wait_drain("t4");
        chk("t4_sticky", overflow, 1);

        // soft reset mid-frame
        s0 = strobe_cnt;
        push(8'h96, 1'b1);
        for (int n = 0; n < 200 && nbits < 3; n++) step();
        chk("t6_bit3", nbits, 3);
        cpu_reset = 1'b1;
        step();
        cpu_reset = 1'b0;
        step();
        chk("t6_sclk", shift_clk, 1);
        chk("t6_sdata", shift_data, 1);
        chk("t6_busy", busy, 0);
        chk("t6_full", rx_full, 0);
        chk("t6_ovf_clr", overflow, 0);
        repeat (20) step();
        chk("t6_fifo_empty", busy, 0);
        chk("t6_no_strobe", strobe_cnt, s0);

        chk("strobe_total", strobe_cnt, 3);
        chk("tx_q_left", tx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
